// File: rtl/uart_byte_tx_if.sv
// ---------------------------------------------------------------------------
// uart_byte_tx_if
// Byte handshake between an upstream producer and the UART transmitter.
//   tx_data  : byte offered by the producer (captured only on handshake)
//   tx_valid : producer has a byte on tx_data
//   tx_ready : transmitter can accept a byte this cycle
// A transfer happens in any cycle where tx_valid and tx_ready are both high.
// ---------------------------------------------------------------------------
interface uart_byte_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  // Producer side: drives the byte and valid, watches ready.
  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  // Transmitter side: consumes the byte and valid, drives ready.
  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_byte_tx.sv
// ---------------------------------------------------------------------------
// uart_byte_tx
// UART transmitter: accepts one byte per valid/ready handshake and shifts it
// out LSB first as start bit, 8 data bits, optional parity bit and 1 or 2
// stop bits.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset (aborts any frame, tx goes high)
//   bus     : slave side of the byte handshake (tx_data/tx_valid/tx_ready)
//   tx      : serial line, idle high, always driven from a flop
//   tx_busy : high while a frame is on the line
// Parameters: CLK_FREQ/BAUD set the bit period (integer division, >= 2),
// PARITY 0=none 1=even 2=odd, STOP_BITS 1 or 2.
// ---------------------------------------------------------------------------
module uart_byte_tx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD      = 115200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_byte_tx_if.slave  bus,
  output logic           tx,
  output logic           tx_busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic PAR_EN   = (PARITY != 0);
  localparam logic PAR_ODD  = (PARITY == 2);
  localparam logic TWO_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state_q,    state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_idx_q,  bit_idx_d;
  logic [7:0]       shift_q,    shift_d;
  logic             parity_q,   parity_d;
  logic             stop_cnt_q, stop_cnt_d;
  logic             tx_q,       tx_d;
  logic             ready_q,    ready_d;
  logic             busy_q,     busy_d;
  logic             bit_end;

  // Terminal count of the baud counter marks the last cycle of a bit period.
  assign bit_end = (baud_cnt_q == CNT_LAST);

  // Next-state logic. tx_d is the value the line takes on the next edge, so
  // each transition loads the first bit of the state being entered; this
  // keeps tx purely registered and every bit exactly CLKS_PER_BIT long.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    ready_d    = ready_q;
    busy_d     = busy_q;

    if (state_q != S_IDLE) begin
      baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.tx_valid && ready_q) begin
          shift_d    = bus.tx_data;
          // Odd parity is the inverse of the data XOR.
          parity_d   = (^bus.tx_data) ^ PAR_ODD;
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b0;
          ready_d    = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_START;
        end
      end

      S_START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          // Index wraps 7 -> 0 as the last data bit finishes.
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            if (PAR_EN) begin
              tx_d    = parity_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          // With two stop bits the first period only flips stop_cnt.
          if (!TWO_STOP || stop_cnt_q) begin
            stop_cnt_d = 1'b0;
            ready_d    = 1'b1;
            busy_d     = 1'b0;
            state_d    = S_IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset forces the line high immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.tx_ready = ready_q;
  assign tx           = tx_q;
  assign tx_busy      = busy_q;

endmodule
